// File: rtl/spm_dp_param_pkg.sv
// spm_dp_param_pkg: shared scratchpad defaults, CPU bus encodings and clear-FSM states
package spm_dp_param_pkg;
  localparam int SPM_DATA_W = 32;
  localparam int SPM_DEPTH = 4096;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic {SPM_ST_CLEAR, SPM_ST_READY} spm_state_e;
endpackage

// File: rtl/spm_dp_param_if.sv
// spm_dp_param_if: one scratchpad access port (active-low strobe and completion)
interface spm_dp_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic as_;
  logic rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic rdy_;
  modport master (output as_, rw, addr, be, wr_data, input rd_data, rdy_);
  modport slave (input as_, rw, addr, be, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/spm_be_ram.sv
// spm_be_ram: true-dual-port read-first array with per-byte write enables and registered reads
module spm_be_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W / 8
)(
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BE_W-1:0]   a_be,
  input  logic [DATA_W-1:0] a_wd,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wd,
  output logic [DATA_W-1:0] b_q
);
  logic [DATA_W-1:0] mem [DEPTH];
  // q only moves on reads so the output holds across idle cycles and writes
  always_ff @(posedge clk) begin
    if (a_en && !a_we) a_q <= mem[a_addr];
    if (b_en && !b_we) b_q <= mem[b_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (a_en && a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
      if (b_en && b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_wd[8*i +: 8];
    end
  end
endmodule

// File: rtl/spm_dp_param.sv
// spm_dp_param: parametrised dual-port scratchpad with post-reset zero clear,
// byte enables, B-wins write collisions and write-through read forwarding
module spm_dp_param
  import spm_dp_param_pkg::*;
#(
  parameter int DATA_W = SPM_DATA_W,
  parameter int DEPTH = SPM_DEPTH,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W / 8
)(
  input  logic clk,
  input  logic reset,
  output logic init_busy,
  spm_dp_param_if.slave a,
  spm_dp_param_if.slave b
);
  spm_state_e state, state_nx;
  logic [ADDR_W-1:0] cnt, ra_addr;
  logic clr, a_acc, b_acc, a_rd, b_rd, a_wr, b_wr, same, a_hv, b_hv;
  logic [BE_W-1:0] ra_be;
  logic [DATA_W-1:0] ra_wd, a_q, b_q, a_fm, b_fm, a_fd, b_fd;

  function automatic logic [DATA_W-1:0] bmask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  assign clr = state == SPM_ST_CLEAR;
  assign init_busy = clr;
  assign a_acc = !clr && a.as_ == ENABLE_;
  assign b_acc = !clr && b.as_ == ENABLE_;
  assign a_wr = a_acc && a.rw == WRITE;
  assign b_wr = b_acc && b.rw == WRITE;
  assign a_rd = a_acc && a.rw == READ;
  assign b_rd = b_acc && b.rw == READ;
  assign same = a.addr == b.addr;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR_ON_RESET != 0 ? SPM_ST_CLEAR : SPM_ST_READY;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= clr ? cnt + ADDR_W'(1) : '0;
    end

  always_comb begin
    state_nx = state;
    state_nx = clr && cnt == ADDR_W'(DEPTH - 1) ? SPM_ST_READY : state_nx;
  end

  // the sequencer owns port A while clearing; A yields collided bytes to B
  assign ra_addr = clr ? cnt : a.addr;
  assign ra_be = clr ? {BE_W{1'b1}} : (b_wr && same ? a.be & ~b.be : a.be);
  assign ra_wd = clr ? {DATA_W{1'b0}} : a.wr_data;

  spm_be_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .a_en(clr || a_acc), .a_we(clr || a_wr), .a_addr(ra_addr), .a_be(ra_be), .a_wd(ra_wd), .a_q(a_q),
    .b_en(b_acc), .b_we(b_wr), .b_addr(b.addr), .b_be(b.be), .b_wd(b.wr_data), .b_q(b_q)
  );

  // read-first RAM returns old data; the other port's same-cycle write bytes are overlaid here
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a.rdy_ <= DISABLE_;
      b.rdy_ <= DISABLE_;
      a_hv <= 1'b0;
      b_hv <= 1'b0;
      a_fm <= '0;
      b_fm <= '0;
      a_fd <= '0;
      b_fd <= '0;
    end else begin
      a.rdy_ <= a_acc ? ENABLE_ : DISABLE_;
      b.rdy_ <= b_acc ? ENABLE_ : DISABLE_;
      if (a_rd) begin
        a_hv <= 1'b1;
        a_fm <= b_wr && same ? bmask(b.be) : '0;
        a_fd <= b.wr_data;
      end
      if (b_rd) begin
        b_hv <= 1'b1;
        b_fm <= a_wr && same ? bmask(a.be) : '0;
        b_fd <= a.wr_data;
      end
    end

  assign a.rd_data = a_hv ? (a_q & ~a_fm) | (a_fd & a_fm) : '0;
  assign b.rd_data = b_hv ? (b_q & ~b_fm) | (b_fd & b_fm) : '0;
endmodule

// File: doc/spm_dp_param.md
Name: spm_dp_param

Overview:
- Parametrised successor to the fixed-size dual-port scratchpad memory.
- Port A serves instruction fetch; port B serves the MEM stage.
- Adds configurable width and depth, per-byte write enables, and defined same-address collision rules.
- Adds a post-reset zero-clear sequencer and an active-low ready handshake, so the pipeline stalls until the memory is valid.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 4096, words per port view; must be a power of two.
- ADDR_W, clog2(DEPTH), word-address width; derived, not overridden.
- BE_W, DATA_W/8, number of byte-enable bits; derived.
- CLEAR_ON_RESET, 1, 1 = zero-fill after reset; 0 = skip straight to READY.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- init_busy  out  1  high while the clear sequencer runs.
- a_as_  in  1  port A access strobe, active-low.
- a_rw  in  1  port A direction, READ/WRITE encoding from the shared CPU header.
- a_addr  in  ADDR_W  port A word address.
- a_be  in  BE_W  port A byte enables; bit i covers data[8i+7:8i].
- a_wr_data  in  DATA_W  port A write data.
- a_rd_data  out  DATA_W  port A read data, registered.
- a_rdy_  out  1  port A completion, active-low.
- b_as_, b_rw, b_addr, b_be, b_wr_data, b_rd_data, b_rdy_: same as port A, for port B.

Behaviour:
- Reset (asynchronous, on assertion):
  - init_busy=1 if CLEAR_ON_RESET else 0.
  - a_rdy_=b_rdy_=1; a_rd_data=b_rd_data=0.
  - FSM=CLEAR (or READY when CLEAR_ON_RESET=0); clear counter=0.
- FSM CLEAR:
  - Each cycle, write 0 to word[cnt]; cnt++.
  - At cnt==DEPTH-1: after that write, go to READY and drop init_busy on the next edge.
  - Duration is exactly DEPTH cycles.
  - Port requests during CLEAR are ignored, not queued. rdy_ stays 1 and the requester holds its request.
- FSM READY:
  - A request is accepted on any edge where as_=0. There is no back-pressure.
  - Read: rd_data updates on the edge after acceptance and rdy_=0 in that same cycle (latency 1).
  - Write: bytes with be=1 update on the acceptance edge; rdy_=0 the following cycle.
  - A write with be=0 completes with rdy_=0 and changes nothing.
  - Back-to-back requests give rdy_=0 every cycle.
  - rdy_ returns to 1 the cycle after the last accepted request.
  - rd_data holds its last read value when idle or after a write.
- Collisions in READY, same address, same cycle:
  - Write/write: for each byte, port B wins where both be=1; otherwise the byte is taken from whichever port enables it.
  - Read/write: the reader returns the new merged data (write-through forwarding), with the same 1-cycle latency.
  - Read/read: both ports return identical data.
- Addresses are ADDR_W wide, so there is no out-of-range case; wrap is implicit.
- Reset asserted mid-operation:
  - In-flight reads are discarded and rdy_=1 immediately (asynchronous).
  - The clear restarts at address 0.
  - Memory contents are undefined until the clear completes.

Decomposition:
- Shared header spm.h holds:
  - defaults SPM_DATA_W and SPM_DEPTH;
  - FSM state encodings SPM_ST_CLEAR / SPM_ST_READY;
  - reuse of the existing ENABLE_/DISABLE_, READ/WRITE and MEMORY_ENABLE macros.
- Sub-module spm_be_ram: a pure true-dual-port inferred array with per-byte write enables and registered outputs, parametrised by DATA_W and DEPTH.
- The top level holds:
  - the clear FSM and counter;
  - port-A write muxing during CLEAR (the sequencer owns port A);
  - collision merge and forwarding;
  - rdy_ generation.

Test Plan:
- Reset then idle, DEPTH=16: init_busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 all return 0x00000000 with rdy_ low 1 cycle after each request.
- After clear, A writes 0xDEADBEEF to address 5 with be=4'b1111; B reads address 5 next cycle → b_rd_data=0xDEADBEEF and b_rdy_=0 one cycle after the request.
- Partial write: address 3 holds 0x11223344; B writes 0xAABBCCDD with be=4'b0101 → a read of address 3 returns 0x11BB33DD.
- Same-cycle write collision at address 7: A writes 0x01010101 with be=1111, B writes 0x02020202 with be=0011 → address 7 reads 0x01010202.
- Same-cycle A read and B write 0xCAFEF00D at address 9 → a_rd_data=0xCAFEF00D next cycle.
- Reset asserted mid-stream of back-to-back reads → rdy_ goes to 1 asynchronously, init_busy=1, the clear restarts from 0, and requests issued during CLEAR never produce rdy_=0.
